// File: rtl/instruction_encoder.sv
// instruction_encoder: rebuilds 16-bit MSP430 instruction words from decoded
// fields and streams them into program memory through a single holding
// register with an auto-incrementing word write pointer.
module instruction_encoder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'hC000),
  parameter int                ERR_W     = 8
) (
  input  logic              MCLK,
  input  logic              RST_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       FS,
  input  logic [15:0]       BranchOffset,
  input  logic [3:0]        srcA,
  input  logic [3:0]        dstA,
  input  logic [1:0]        As,
  input  logic              Ad,
  input  logic              BW,
  input  logic              OneOp,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  logic              ready_en;
  logic              accept;
  logic              wr_done;
  logic              enc_legal;
  logic [15:0]       enc_word;
  logic              jump_ok;
  logic [ADDR_W-1:0] load_addr;
  logic              unused_bits;

  // OneOp is only a hint and the pointer is word aligned, so these bits are
  // intentionally left out of the datapath.
  assign unused_bits = ^{OneOp, addr_in[0]};

  assign load_addr = {addr_in[ADDR_W-1:1], 1'b0};
  assign in_ready  = ready_en && (!mem_we || mem_ready);
  assign accept    = in_valid && in_ready;
  assign wr_done   = mem_we && mem_ready;

  // A jump offset must be even and fit a sign-extended 11-bit byte offset.
  assign jump_ok = (BranchOffset[0] == 1'b0) &&
                   (BranchOffset[15:11] == {5{BranchOffset[10]}});

  // Assemble the instruction word for the format selected by the opcode nibble.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b0;
    if (FS == 16'h1300) begin
      enc_word  = 16'h1300;
      enc_legal = 1'b1;
    end else begin
      case (FS[15:12])
        4'h0: begin
          enc_word  = 16'h0000;
          enc_legal = 1'b0;
        end
        4'h1: begin
          enc_word  = {FS[15:7], BW, As, dstA};
          enc_legal = 1'b1;
        end
        4'h2, 4'h3: begin
          enc_word  = {FS[15:10], BranchOffset[10:1]};
          enc_legal = jump_ok;
        end
        default: begin
          enc_word  = {FS[15:12], srcA, Ad, BW, As, dstA};
          enc_legal = 1'b1;
        end
      endcase
    end
  end

  // Hold off accepting bundles until the first clock after reset release.
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Holding register: load a legal word on accept, retire it on completion.
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      mem_we    <= 1'b0;
      mem_wdata <= 16'h0000;
    end else if (accept && enc_legal) begin
      mem_we    <= 1'b1;
      mem_wdata <= enc_word;
    end else if (wr_done) begin
      mem_we    <= 1'b0;
    end
  end

  // Write pointer: advance per completed write; loads are dropped while a write stalls.
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      mem_addr <= BASE_ADDR;
    end else if (wr_done) begin
      mem_addr <= addr_load ? load_addr : mem_addr + ADDR_W'(2);
    end else if (addr_load && !mem_we) begin
      mem_addr <= load_addr;
    end
  end

  // Flag dropped bundles with a one-cycle pulse and a saturating count.
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= accept && !enc_legal;
      if (accept && !enc_legal && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Inverse of the CPU instruction decoder. It accepts decoded instruction fields (FS, register addresses, address modes, B/W, branch offset) over a valid/ready handshake and re-assembles the 16-bit MSP430 instruction word. It writes each word to program memory through a buffered write port with an auto-incrementing address. It is used by the boot/program loader and the self-check bench to generate instruction streams that the decoder consumes.

Parameters:
ADDR_W, 16, memory byte-address width
BASE_ADDR, 16'hC000, address loaded on reset
ERR_W, 8, width of saturating error counter

Ports:
MCLK  in  1  system clock, rising edge
RST_n  in  1  asynchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
FS  in  16  function select (opcode field, masked form)
BranchOffset  in  16  signed byte offset for jumps
srcA  in  4  source register address
dstA  in  4  destination register address
As  in  2  source address mode
Ad  in  1  destination address mode
BW  in  1  byte/word
OneOp  in  1  format-2 hint (informational only)
addr_load  in  1  load write pointer from addr_in
addr_in  in  ADDR_W  new write pointer
mem_we  out  1  write request, held until mem_ready
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word write address
mem_wdata  out  16  encoded instruction word
err  out  1  one-cycle pulse: illegal bundle dropped
err_cnt  out  ERR_W  saturating count of dropped bundles

Behaviour:
- Reset (async, RST_n=0): mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, err=0, err_cnt=0. in_ready goes to 1 after the first clock edge following deassertion.
- Encoding, selected by FS[15:12] (combinational, registered on accept):
  - FS==16'h1300 (RETI) -> 16'h1300.
  - 1 -> {FS[15:7], BW, As, dstA}.
  - 2,3 (jumps) -> {FS[15:10], BranchOffset[10:1]}.
  - 4..F (format 1) -> {FS[15:12], srcA, Ad, BW, As, dstA}.
  - 0 -> illegal; drop the bundle.
- Jump legality: BranchOffset[0]==0 and BranchOffset[15:11] all equal to BranchOffset[10]; otherwise drop the bundle.
- Dropped bundle: consumed (handshake completes), no write. err=1 the next cycle. err_cnt increments and saturates at all-ones.
- Output stage: a single holding register. in_ready = !mem_we || mem_ready.
- Accept: in_valid && in_ready. A legal bundle appears on mem_we/mem_wdata the next cycle (latency 1). Back-to-back accepts sustain 1 word/cycle while mem_ready=1.
- mem_we, mem_wdata and mem_addr are stable while mem_we=1 && mem_ready=0.
- Write completion: mem_we && mem_ready. mem_addr then increments by 2 and wraps modulo 2^ADDR_W (FFFE -> 0000).
- addr_load:
  - Takes effect at the clock edge.
  - If a write completes in the same cycle, that write uses the old address, and the pointer becomes addr_in (no +2).
  - If a write is pending and not completing, the pointer is not modified. addr_load is ignored and the load is not queued.
  - addr_in[0] is forced to 0.
- OneOp does not affect encoding.
- Reset mid-operation: the pending write is discarded, mem_we drops immediately, and the pointer returns to BASE_ADDR.

Test Plan:
- FS=4000, srcA=5, dstA=6, As=0, Ad=0, BW=0, mem_ready=1 -> next cycle mem_we=1, mem_wdata=4506, mem_addr=C000; following word at C002.
- FS=5000, srcA=4, As=3, Ad=1, BW=1, dstA=7 -> 54F7. FS=1200, As=0, dstA=A -> 120A. FS=1300 -> 1300.
- FS=3C00, BranchOffset=FFFC -> 3FFE. BranchOffset=0800 or 0003 -> no write, err pulse, err_cnt=1. FS=0000 -> dropped, err_cnt=2.
- mem_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, mem_wdata/mem_addr stable. Release -> word written, next bundle accepted the same cycle.
- Pointer at FFFE, write completes -> mem_addr=0000. addr_load=1, addr_in=8001 on a completing write -> that write goes to the old address, pointer becomes 8000.
- Assert RST_n=0 with mem_we=1 pending -> mem_we=0 asynchronously, mem_addr=C000, err_cnt=0.
